// File: rtl/scr1_dmi_hs.sv
// DTM-side Debug Module Interface with a multi-cycle request/response
// handshake towards the Debug Module. Owns the DTMCS / DMI data registers,
// the sticky dmistat, dmireset / dmihardreset and a response timeout.
//
// Handshake: dmi_req is a registered valid that rises one cycle after an
// accepted DMI update and stays high, with dmi_wr/dmi_addr/dmi_wdata frozen,
// until the DM answers with dmi_resp (one-cycle strobe, sampled only while
// dmi_req=1). dmi_err and dmi_rdata are meaningful only in that cycle, and
// dmi_rdata only for reads. A timeout or dmihardreset also ends the request.
module scr1_dmi_hs #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int CH_ID_W   = 2,
  parameter int DTMCS_ID  = 1,
  parameter int DMI_ID    = 2,
  parameter int IDLE_HINT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dtm_ch_sel,
  input  logic [CH_ID_W-1:0] dtm_ch_id,
  input  logic               dtm_ch_capture,
  input  logic               dtm_ch_shift,
  input  logic               dtm_ch_update,
  input  logic               dtm_ch_tdi,
  output logic               dtm_ch_tdo,
  output logic               dmi_req,
  output logic               dmi_wr,
  output logic [AW-1:0]      dmi_addr,
  output logic [DW-1:0]      dmi_wdata,
  input  logic               dmi_resp,
  input  logic               dmi_err,
  input  logic [DW-1:0]      dmi_rdata
);

  localparam int DRW   = AW + DW + 2;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DRW-1:0]     dr_q, dr_d;
  logic [1:0]         stat_q, stat_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               wr_q, wr_d;

  logic               is_dtmcs;
  logic               is_dmi;
  logic               busy;
  logic [1:0]         dr_op;
  logic [31:0]        dtmcs_cap;

  assign is_dtmcs  = (dtm_ch_id == CH_ID_W'(DTMCS_ID));
  assign is_dmi    = (dtm_ch_id == CH_ID_W'(DMI_ID));
  assign busy      = (state_q == ST_REQ);
  assign dr_op     = dr_q[1:0];
  // version 1, abits, dmistat, idle hint; dmireset/dmihardreset read as 0
  assign dtmcs_cap = {14'd0, 2'b00, 1'b0, 3'(IDLE_HINT), stat_q, 6'(AW), 4'd1};

  // Next-state logic: DR chain, request FSM, sticky status and latched fields
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dr_d    = dr_q;
    stat_d  = stat_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;

    // DR chain: capture wins over shift; unknown chains behave as 1-bit bypass
    if (dtm_ch_sel && dtm_ch_capture) begin
      if (is_dtmcs) begin
        dr_d = DRW'(dtmcs_cap);
      end else if (is_dmi) begin
        dr_d = {addr_q, rdata_q, (busy ? 2'b11 : stat_q)};
        // a host that reads while busy must see the sticky busy error later
        if (busy && (stat_d == 2'd0)) stat_d = 2'd3;
      end else begin
        dr_d = '0;
      end
    end else if (dtm_ch_sel && dtm_ch_shift) begin
      if (is_dtmcs) begin
        dr_d = DRW'({dtm_ch_tdi, dr_q[31:1]});
      end else if (is_dmi) begin
        dr_d = {dtm_ch_tdi, dr_q[DRW-1:1]};
      end else begin
        dr_d = DRW'(dtm_ch_tdi);
      end
    end

    // Request FSM: a response ends the request, otherwise the timeout may
    case (state_q)
      ST_REQ: begin
        if (dmi_resp) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!wr_q) rdata_d = dmi_rdata;
          if (dmi_err && (stat_d == 2'd0)) stat_d = 2'd2;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (stat_d == 2'd0) stat_d = 2'd2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // DMI update: sticky status blocks everything, busy flags an overrun
    if (dtm_ch_sel && dtm_ch_update && is_dmi) begin
      if (stat_q != 2'd0) begin
        stat_d = stat_d;
      end else if (busy) begin
        if (stat_d == 2'd0) stat_d = 2'd3;
      end else if ((dr_op == 2'd1) || (dr_op == 2'd2)) begin
        addr_d  = dr_q[DRW-1:DW+2];
        wdata_d = dr_q[DW+1:2];
        wr_d    = (dr_op == 2'd2);
        state_d = ST_REQ;
        cnt_d   = '0;
      end
    end

    // DTMCS update: dmireset clears status; dmihardreset also drops the request
    // and discards any response arriving in the same cycle
    if (dtm_ch_sel && dtm_ch_update && is_dtmcs) begin
      if (dr_q[16]) stat_d = 2'd0;
      if (dr_q[17]) begin
        stat_d  = 2'd0;
        state_d = ST_IDLE;
        cnt_d   = '0;
        rdata_d = rdata_q;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dr_q    <= '0;
      stat_q  <= 2'd0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign dtm_ch_tdo = dr_q[0];
  assign dmi_req    = (state_q == ST_REQ);
  assign dmi_wr     = wr_q;
  assign dmi_addr   = addr_q;
  assign dmi_wdata  = wdata_q;

endmodule

// File: tb/tb_scr1_dmi_hs.sv
// Testbench for scr1_dmi_hs: scan drivers, a DM responder, and two monitors
// (scan-out and DMI request) fed from expected queues by a reference model.
module tb_scr1_dmi_hs;

  localparam int AW       = 7;
  localparam int DW       = 32;
  localparam int DRW      = AW + DW + 2;
  localparam int TMO      = 4;
  localparam int DTMCS_ID = 1;
  localparam int DMI_ID   = 2;
  localparam int REQ_W    = 8 + 1 + AW + DW;
  localparam int PLAN_W   = 1 + 1 + 4 + DW;

  logic          clk;
  logic          rst_n;
  logic          dtm_ch_sel;
  logic [1:0]    dtm_ch_id;
  logic          dtm_ch_capture;
  logic          dtm_ch_shift;
  logic          dtm_ch_update;
  logic          dtm_ch_tdi;
  logic          dtm_ch_tdo;
  logic          dmi_req;
  logic          dmi_wr;
  logic [AW-1:0] dmi_addr;
  logic [DW-1:0] dmi_wdata;
  logic          dmi_resp;
  logic          dmi_err;
  logic [DW-1:0] dmi_rdata;

  scr1_dmi_hs #(
    .AW(AW), .DW(DW), .CH_ID_W(2), .DTMCS_ID(DTMCS_ID), .DMI_ID(DMI_ID),
    .IDLE_HINT(1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dtm_ch_sel(dtm_ch_sel), .dtm_ch_id(dtm_ch_id),
    .dtm_ch_capture(dtm_ch_capture), .dtm_ch_shift(dtm_ch_shift),
    .dtm_ch_update(dtm_ch_update), .dtm_ch_tdi(dtm_ch_tdi), .dtm_ch_tdo(dtm_ch_tdo),
    .dmi_req(dmi_req), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_resp(dmi_resp), .dmi_err(dmi_err), .dmi_rdata(dmi_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [DRW-1:0]    scan_exp_q[$];
  logic [REQ_W-1:0]  req_exp_q[$];
  logic [PLAN_W-1:0] plan_q[$];

  // reference model state
  logic [1:0]    m_stat;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  bit            m_busy;
  bit            p_read, p_timeout, p_err;
  logic [DW-1:0] p_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // DM responder: answers the k-th request cycle, drives noise otherwise
  initial begin : responder
    logic [PLAN_W-1:0] pl;
    bit act;
    int cyc;
    dmi_resp = 1'b0; dmi_err = 1'b0; dmi_rdata = '0;
    act = 1'b0; cyc = 0; pl = '0;
    forever begin
      @(negedge clk);
      dmi_resp  = 1'b0;
      dmi_err   = 1'($urandom_range(0, 1));
      dmi_rdata = $urandom;
      if (rst_n && dmi_req) begin
        if (!act) begin
          act = 1'b1;
          cyc = 0;
          if (plan_q.size() > 0) pl = plan_q.pop_front();
          else pl = {1'b1, {(PLAN_W-1){1'b0}}};
        end
        cyc++;
        if (!pl[PLAN_W-1] && (cyc == int'(pl[DW+3:DW]))) begin
          dmi_resp  = 1'b1;
          dmi_err   = pl[PLAN_W-2];
          dmi_rdata = pl[DW-1:0];
        end
      end else begin
        act = 1'b0;
      end
    end
  end

  // scan-out monitor: assembles tdo bits between capture and update
  initial begin : scan_mon
    logic [DRW-1:0] col;
    logic [DRW-1:0] e;
    int nb;
    bit act;
    act = 1'b0; nb = 0; col = '0;
    forever begin
      @(negedge clk);
      if (dtm_ch_sel && dtm_ch_capture) begin
        act = 1'b1; nb = 0; col = '0;
      end else if (dtm_ch_sel && dtm_ch_shift && act) begin
        if (nb < DRW) col[nb] = dtm_ch_tdo;
        nb++;
      end else if (dtm_ch_sel && dtm_ch_update && act) begin
        act = 1'b0;
        if (scan_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scan_unexpected: got %0h expected none", col);
        end else begin
          e = scan_exp_q.pop_front();
          check("scan_out", 64'(col), 64'(e));
        end
      end
    end
  end

  // DMI request monitor: fields at rise, stability while held, length at fall
  initial begin : req_mon
    logic [REQ_W-1:0] e;
    bit act, stable;
    int len;
    act = 1'b0; stable = 1'b1; len = 0; e = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else if (dmi_req && !act) begin
        act = 1'b1; len = 1; stable = 1'b1;
        if (req_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr %0h expected no request", dmi_addr);
          e = {8'd0, dmi_wr, dmi_addr, dmi_wdata};
        end else begin
          e = req_exp_q.pop_front();
          check("req_wr", 64'(dmi_wr), 64'(e[AW+DW]));
          check("req_addr", 64'(dmi_addr), 64'(e[AW+DW-1:DW]));
          check("req_wdata", 64'(dmi_wdata), 64'(e[DW-1:0]));
        end
      end else if (dmi_req && act) begin
        len++;
        if ({dmi_wr, dmi_addr, dmi_wdata} !== e[AW+DW:0]) stable = 1'b0;
      end else if (!dmi_req && act) begin
        act = 1'b0;
        check("req_len", 64'(len), 64'(e[REQ_W-1 -: 8]));
        check("req_stable", 64'(stable), 64'd1);
      end
    end
  end

  // driver tasks
  task automatic run_scan(input logic [1:0] id, input logic [DRW-1:0] din, input int n);
    @(posedge clk); #1;
    dtm_ch_sel = 1'b1; dtm_ch_id = id; dtm_ch_capture = 1'b1;
    @(posedge clk); #1;
    dtm_ch_capture = 1'b0; dtm_ch_shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      dtm_ch_tdi = din[i];
      @(posedge clk); #1;
    end
    dtm_ch_shift = 1'b0; dtm_ch_tdi = 1'b0; dtm_ch_update = 1'b1;
    @(posedge clk); #1;
    dtm_ch_update = 1'b0;
  endtask

  task automatic pulse_update(input logic [1:0] id);
    dtm_ch_sel = 1'b1; dtm_ch_id = id; dtm_ch_update = 1'b1;
    @(posedge clk); #1;
    dtm_ch_update = 1'b0;
  endtask

  task automatic dtmcs_scan(input bit clr, input bit hard);
    logic [DRW-1:0] e, d;
    e = DRW'(32'h1000 + (32'(m_stat) << 10) + (AW << 4) + 1);
    scan_exp_q.push_back(e);
    d = DRW'($urandom);
    d[16] = clr;
    d[17] = hard;
    if (clr || hard) m_stat = 2'd0;
    if (hard) m_busy = 1'b0;
    run_scan(2'(DTMCS_ID), d, 32);
  endtask

  task automatic dmi_scan(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit no_resp, input bit err,
                          input int k, input logic [DW-1:0] rdata);
    logic [DRW-1:0] e;
    int len;
    e = {m_addr, m_rdata, (m_busy ? 2'b11 : m_stat)};
    scan_exp_q.push_back(e);
    if (m_busy && m_stat == 2'd0) m_stat = 2'd3;
    if (m_stat == 2'd0 && !m_busy && (op == 2'd1 || op == 2'd2)) begin
      m_addr    = addr;
      m_busy    = 1'b1;
      p_read    = (op == 2'd1);
      p_timeout = no_resp || (k > TMO);
      p_err     = err;
      p_rdata   = rdata;
      len       = p_timeout ? TMO : k;
      req_exp_q.push_back({8'(len), (op == 2'd2), addr, data});
      plan_q.push_back({no_resp, err, 4'(k), rdata});
    end
    run_scan(2'(DMI_ID), {addr, data, op}, DRW);
  endtask

  task automatic finish_req();
    repeat (TMO + 4) @(posedge clk);
    #1;
    if (m_busy) begin
      if (p_timeout) begin
        if (m_stat == 2'd0) m_stat = 2'd2;
      end else begin
        if (p_read) m_rdata = p_rdata;
        if (p_err && m_stat == 2'd0) m_stat = 2'd2;
      end
      m_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_stat = 2'd0; m_rdata = '0; m_addr = '0; m_busy = 1'b0;
    p_read = 1'b0; p_timeout = 1'b0; p_err = 1'b0; p_rdata = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, 64'(dmi_req), 64'd0);
    check({tag, "_wr"}, 64'(dmi_wr), 64'd0);
    check({tag, "_addr"}, 64'(dmi_addr), 64'd0);
    check({tag, "_wdata"}, 64'(dmi_wdata), 64'd0);
    check({tag, "_tdo"}, 64'(dtm_ch_tdo), 64'd0);
  endtask

  // main stimulus
  initial begin : main
    logic [DRW-1:0] din, e;
    logic [DW-1:0] r;
    rst_n = 1'b0;
    dtm_ch_sel = 1'b0; dtm_ch_id = 2'd0; dtm_ch_capture = 1'b0;
    dtm_ch_shift = 1'b0; dtm_ch_update = 1'b0; dtm_ch_tdi = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // DTMCS after reset reads 0x00001071
    dtmcs_scan(1'b0, 1'b0);

    // write, response in the 3rd request cycle
    dmi_scan(2'd2, 7'h10, 32'hA5A5_0001, 1'b0, 1'b0, 3, 32'h0);
    finish_req();
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    // read returning 0x12345678
    dmi_scan(2'd1, 7'h04, 32'h0, 1'b0, 1'b0, 2, 32'h1234_5678);
    finish_req();
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    // capture while busy: op=3, following write ignored, sticky until dmireset
    r = $urandom;
    dmi_scan(2'd1, 7'h22, $urandom, 1'b0, 1'b0, 4, r);
    dmi_scan(2'd2, 7'h23, $urandom, 1'b0, 1'b0, 1, 32'h0);
    finish_req();
    dtmcs_scan(1'b0, 1'b0);
    dtmcs_scan(1'b1, 1'b0);
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    // update while busy sets stat=3 without a second request
    dmi_scan(2'd1, 7'h33, $urandom, 1'b0, 1'b0, 3, $urandom);
    pulse_update(2'(DMI_ID));
    if (m_stat == 2'd0) m_stat = 2'd3;
    finish_req();
    dtmcs_scan(1'b0, 1'b0);
    dtmcs_scan(1'b1, 1'b0);

    // timeout on a write, then an erroring read
    dmi_scan(2'd2, 7'h11, $urandom, 1'b1, 1'b0, 1, 32'h0);
    finish_req();
    dtmcs_scan(1'b0, 1'b0);
    dtmcs_scan(1'b1, 1'b0);
    dmi_scan(2'd1, 7'h12, $urandom, 1'b0, 1'b1, 1, 32'hCAFE_0003);
    finish_req();
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);
    dtmcs_scan(1'b1, 1'b0);

    // response in the last cycle before the timeout still completes normally
    dmi_scan(2'd1, 7'h13, $urandom, 1'b0, 1'b0, TMO, 32'h0BAD_F00D);
    finish_req();
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    // unselected chain behaves as a 1-bit bypass
    din = {$urandom, $urandom};
    e = '0;
    for (int i = 1; i < 6; i++) e[i] = din[i-1];
    scan_exp_q.push_back(e);
    run_scan(2'd0, din, 6);

    // dmihardreset in the same cycle as an erroring read response
    dmi_scan(2'd1, 7'h05, 32'h0000_8000 | 32'($urandom_range(0, 16'h3FFF)), 1'b0, 1'b1, 2,
             32'hDEAD_BEEF);
    @(posedge clk); #1;
    pulse_update(2'(DTMCS_ID));
    m_stat = 2'd0; m_busy = 1'b0;
    check("hardreset_req_low", 64'(dmi_req), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      dmi_scan(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
               $urandom_range(1, 5), $urandom);
      finish_req();
      if ($urandom_range(0, 2) == 0) dtmcs_scan(1'($urandom_range(0, 1)), 1'b0);
      if (m_stat != 2'd0 && $urandom_range(0, 1) == 0) dtmcs_scan(1'b1, 1'b0);
    end
    dtmcs_scan(1'b1, 1'b0);

    // asynchronous reset in the middle of a write request
    dmi_scan(2'd2, 7'h44, $urandom | 32'h1, 1'b1, 1'b0, 1, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    plan_q.delete();
    model_reset();
    dtmcs_scan(1'b0, 1'b0);
    dmi_scan(2'd0, 7'h00, 32'h0, 1'b0, 1'b0, 1, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("scan_queue_empty", 64'(scan_exp_q.size()), 64'd0);
    check("req_queue_empty", 64'(req_exp_q.size()), 64'd0);
    check("final_req_low", 64'(dmi_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
